// File: rtl/instr_fetch_queue_pkg.sv
// -----------------------------------------------------------------------------
// instr_fetch_queue_pkg
//   Shared types and constants for the prefetching instruction fetch queue.
//   ifq_entry_t is one buffered {pc, instr} pair; IFQ_ENTRY_W is its packed width.
//   align_pc() forces a fetch PC onto a word boundary (low two bits cleared).
// -----------------------------------------------------------------------------
package instr_fetch_queue_pkg;

    localparam int PC_W        = 9;    // fetch PC width, wraps modulo 2**PC_W
    localparam int INS_W       = 32;   // instruction width
    localparam int IFQ_DEPTH   = 4;    // default FIFO depth (power of two, >= 2)
    localparam int IFQ_PC_STEP = 4;    // byte distance between sequential fetches

    typedef struct packed {
        logic [PC_W-1:0]  pc;
        logic [INS_W-1:0] instr;
    } ifq_entry_t;

    localparam int IFQ_ENTRY_W = $bits(ifq_entry_t);

    function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] pc);
        return {pc[PC_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/ifq_storage.sv
// -----------------------------------------------------------------------------
// ifq_storage
//   DEPTH x ifq_entry_t register array backing the fetch queue. One write port,
//   one asynchronous read port. Entry validity is tracked by the owner's count.
// Ports
//   clk      in   clock
//   wr_en    in   write wr_data into slot wr_ptr at the rising edge
//   wr_ptr   in   write slot index
//   wr_data  in   packed ifq_entry_t to store
//   rd_ptr   in   read slot index
//   rd_data  out  packed ifq_entry_t held in slot rd_ptr
// -----------------------------------------------------------------------------
module ifq_storage
    import instr_fetch_queue_pkg::*;
#(
    parameter int DEPTH = IFQ_DEPTH,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   wr_en,
    input  logic [PTR_W-1:0]       wr_ptr,
    input  logic [IFQ_ENTRY_W-1:0] wr_data,
    input  logic [PTR_W-1:0]       rd_ptr,
    output logic [IFQ_ENTRY_W-1:0] rd_data
);

    logic [IFQ_ENTRY_W-1:0] mem [DEPTH];

    // NOTE: the data array has no reset; a slot is only read once the queue's
    // count says it holds a written entry, so clearing it would buy nothing.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/instr_fetch_queue.sv
// -----------------------------------------------------------------------------
// instr_fetch_queue
//   Prefetching fetch stage. Drives a synchronous instruction memory (data one
//   cycle after the request) and buffers {pc, instr} pairs in a DEPTH-entry FIFO
//   presented to decode through a valid/ready handshake. A redirect flushes the
//   queue and restarts fetch at the (word aligned) redirect PC.
// Configuration
//   IFQ_PERF_CNT_EN  when defined, adds saturating perf_flush_cnt (redirect
//                    cycles) and perf_starve_cnt (deq_ready & !deq_valid cycles).
// Ports
//   clk, reset       clock; synchronous active-high reset
//   imem_req         instruction memory read strobe
//   imem_addr        read address (the fetch PC)
//   imem_rdata       read data, valid the cycle after imem_req
//   redirect         flush and restart at redirect_pc (low 2 bits ignored)
//   deq_valid        head entry valid
//   deq_ready        consumer accepts the head entry
//   deq_pc/instr     head entry contents (zero while deq_valid is low)
//   occupancy        number of valid FIFO entries
//   perf_*_cnt       optional performance counters (IFQ_PERF_CNT_EN)
// -----------------------------------------------------------------------------
module instr_fetch_queue
    import instr_fetch_queue_pkg::*;
#(
    parameter int DEPTH = IFQ_DEPTH
) (
    input  logic                       clk,
    input  logic                       reset,
    output logic                       imem_req,
    output logic [PC_W-1:0]            imem_addr,
    input  logic [INS_W-1:0]           imem_rdata,
    input  logic                       redirect,
    input  logic [PC_W-1:0]            redirect_pc,
    output logic                       deq_valid,
    input  logic                       deq_ready,
    output logic [PC_W-1:0]            deq_pc,
    output logic [INS_W-1:0]           deq_instr,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
`ifdef IFQ_PERF_CNT_EN
    ,
    output logic [31:0]                perf_flush_cnt,
    output logic [31:0]                perf_starve_cnt
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W+1)'(DEPTH);

    logic [PC_W-1:0]  fpc;       // next fetch PC
    logic [PC_W-1:0]  req_pc;    // PC of the outstanding request
    logic             inflight;  // a response arrives this cycle
    logic             kill;      // the arriving response belongs to a flushed stream
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;

    logic             fire;
    logic             enq;
    logic [CNT_W:0]   committed;
    logic             has_room;

    logic [IFQ_ENTRY_W-1:0] wr_data;
    logic [IFQ_ENTRY_W-1:0] rd_data;
    ifq_entry_t             head_entry;

    // Handshake and issue decisions.
    // committed counts slots already spoken for at the coming edge: entries that
    // stay in the queue plus the response arriving now.
    // NOTE: every always_comb output gets a default first so no path can leave
    // it unassigned and infer a latch.
    always_comb begin
        fire      = 1'b0;
        committed = '0;
        has_room  = 1'b0;
        imem_req  = 1'b0;
        enq       = 1'b0;

        fire      = deq_valid & deq_ready;
        committed = {1'b0, count} + (CNT_W+1)'(inflight) - (CNT_W+1)'(fire);
        has_room  = committed < DEPTH_C;
        imem_req  = !reset && !redirect && has_room;
        enq       = inflight && !kill && !redirect && !reset;
    end

    assign imem_addr = fpc;
    assign deq_valid = (count != '0);
    assign occupancy = count;
    assign wr_data   = {req_pc, imem_rdata};

    ifq_storage #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_storage (
        .clk     (clk),
        .wr_en   (enq),
        .wr_ptr  (tail),
        .wr_data (wr_data),
        .rd_ptr  (head),
        .rd_data (rd_data)
    );

    assign head_entry = rd_data;
    // Outputs read as zero while empty so reset and flush leave a clean value.
    assign deq_pc     = deq_valid ? head_entry.pc    : '0;
    assign deq_instr  = deq_valid ? head_entry.instr : '0;

    // Fetch PC, outstanding request and FIFO bookkeeping.
    // A redirect empties the queue outright, so a same-cycle fire needs no pop.
    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (reset) begin
            fpc      <= '0;
            req_pc   <= '0;
            inflight <= 1'b0;
            kill     <= 1'b0;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
        end else if (redirect) begin
            fpc      <= align_pc(redirect_pc);
            inflight <= 1'b0;
            kill     <= inflight;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
        end else begin
            if (imem_req) begin
                fpc    <= fpc + PC_W'(IFQ_PC_STEP);
                req_pc <= fpc;
            end
            inflight <= imem_req;
            kill     <= 1'b0;
            if (enq) begin
                tail <= tail + 1'b1;
            end
            if (fire) begin
                head <= head + 1'b1;
            end
            count <= count + CNT_W'(enq) - CNT_W'(fire);
        end
    end

`ifdef IFQ_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_flush_cnt  <= '0;
            perf_starve_cnt <= '0;
        end else begin
            if (redirect && perf_flush_cnt != '1) begin
                perf_flush_cnt <= perf_flush_cnt + 32'd1;
            end
            if (deq_ready && !deq_valid && perf_starve_cnt != '1) begin
                perf_starve_cnt <= perf_starve_cnt + 32'd1;
            end
        end
    end
`endif

    // The issue rule keeps one slot free for every response in flight.
    a_no_overflow : assert property (@(posedge clk) disable iff (reset)
        !(enq && !fire && count == DEPTH_C[CNT_W-1:0]));

endmodule
